fb_clk_switch_ctrl: RTL

Sequencer for the glitch-free N:1 clock switch. It accepts source-change requests over a valid/ready handshake and checks that the target clock is toggling before driving the switch `select`. It holds `select` stable while the switch settles, monitors liveness of every source, and falls back automatically when the active source dies. It runs on an always-on reference clock and sits between the register block/power controller and the clock switch.

---
 rtl/fb_clk_switch_if.sv | 23 ++
 rtl/fb_clk_switch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fb_clk_switch_if.sv
// Request/status bundle between the power controller and the clock switch
// sequencer.
interface fb_clk_switch_if #(
   parameter int M = 2
);
   logic         req_valid;
   logic [M-1:0] req_sel;
   logic         req_ready;
   logic         busy;
   logic         done;
   logic         err;
   logic [1:0]   err_code;

   modport master (
      output req_valid, req_sel,
      input  req_ready, busy, done, err, err_code
   );

   modport slave (
      input  req_valid, req_sel,
      output req_ready, busy, done, err, err_code
   );
endinterface

// File: rtl/fb_clk_switch_ctrl.sv
// Sequencer for the glitch-free N:1 clock switch: liveness-checks the target
// before moving select, holds select while settling, fails over when dead.
module fb_clk_switch_ctrl #(
   parameter int N           = 4,
   parameter int M           = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CHK_CYC     = 64,
   parameter int MIN_EDGES   = 4,
   parameter int SETTLE_CYC  = 32,
   parameter int LOSS_CYC    = 128,
   parameter int FALLBACK    = 0
) (
   input  logic           clk,
   input  logic           reset_n,
   fb_clk_switch_if.slave req,
   input  logic [N-1:0]   clk_tog,
   output logic [M-1:0]   select,
   output logic [N-1:0]   clk_active
);
   localparam int IW = $clog2(LOSS_CYC + 1);
   localparam int WW = $clog2(CHK_CYC + 1);
   localparam int EW = $clog2(MIN_EDGES + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int NP = 2 ** M;
   localparam logic [M-1:0] FB_SEL = M'(FALLBACK);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_SWITCH,
      S_FAIL
   } state_t;

   logic [N-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [N-1:0]                  prev_q, prev_d;
   logic [N-1:0]                  seen_q, seen_d;
   logic [N-1:0][IW-1:0]          idle_q, idle_d;
   logic [N-1:0]                  edge_w;
   logic [NP-1:0]                 edge_pad;
   logic [NP-1:0]                 act_pad;

   state_t         state_q, state_d;
   logic [M-1:0]   tgt_q, tgt_d;
   logic [M-1:0]   sel_q, sel_d;
   logic [WW-1:0]  win_q, win_d;
   logic [EW-1:0]  edg_q, edg_d;
   logic [SW-1:0]  set_q, set_d;
   logic           fo_q, fo_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [1:0]     code_q, code_d;
   logic           rdy_q;
   logic           fo_cond;
   logic           ready_w;
   logic           busy_w;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         sync_d[i] = (sync_q[i] << 1) | SYNC_STAGES'(clk_tog[i]);
         prev_d[i] = sync_q[i][SYNC_STAGES-1];
         edge_w[i] = sync_q[i][SYNC_STAGES-1] ^ prev_q[i];
         seen_d[i] = seen_q[i] | edge_w[i];
         if (edge_w[i])
            idle_d[i] = '0;
         else if (idle_q[i] != IW'(LOSS_CYC))
            idle_d[i] = idle_q[i] + 1'b1;
         else
            idle_d[i] = idle_q[i];
         clk_active[i] = seen_q[i] && (idle_q[i] < IW'(LOSS_CYC));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= '0;
         seen_q <= '0;
         idle_q <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         seen_q <= seen_d;
         idle_q <= idle_d;
      end
   end

   // Padded so select/target can index safely when N < 2**M.
   assign edge_pad = NP'(edge_w);
   assign act_pad  = NP'(clk_active);
   assign fo_cond  = !act_pad[sel_q] && (sel_q != FB_SEL);

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      sel_d   = sel_q;
      win_d   = win_q;
      edg_d   = edg_q;
      set_d   = set_q;
      fo_d    = fo_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      ready_w = 1'b0;
      busy_w  = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            ready_w = rdy_q && !fo_cond;
            if (fo_cond) begin
               sel_d   = FB_SEL;
               fo_d    = 1'b1;
               set_d   = '0;
               state_d = S_SWITCH;
            end else if (req.req_valid && ready_w) begin
               if (int'(req.req_sel) >= N) begin
                  err_d  = 1'b1;
                  code_d = 2'd2;
               end else if (req.req_sel == sel_q) begin
                  done_d = 1'b1;
                  code_d = 2'd0;
               end else begin
                  tgt_d   = req.req_sel;
                  win_d   = '0;
                  edg_d   = '0;
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            win_d = win_q + 1'b1;
            if (edge_pad[tgt_q] && (edg_q != EW'(MIN_EDGES)))
               edg_d = edg_q + 1'b1;
            if (edg_d == EW'(MIN_EDGES)) begin
               sel_d   = tgt_q;
               set_d   = '0;
               fo_d    = 1'b0;
               state_d = S_SWITCH;
            end else if (win_q == WW'(CHK_CYC - 1)) begin
               state_d = S_FAIL;
            end
         end
         S_SWITCH: begin
            set_d = set_q + 1'b1;
            if (set_q == SW'(SETTLE_CYC)) begin
               state_d = S_IDLE;
               set_d   = '0;
               fo_d    = 1'b0;
               if (fo_q) begin
                  err_d  = 1'b1;
                  code_d = 2'd3;
               end else begin
                  done_d = 1'b1;
                  code_d = 2'd0;
               end
            end
         end
         S_FAIL: begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tgt_q   <= FB_SEL;
         sel_q   <= FB_SEL;
         win_q   <= '0;
         edg_q   <= '0;
         set_q   <= '0;
         fo_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'd0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         sel_q   <= sel_d;
         win_q   <= win_d;
         edg_q   <= edg_d;
         set_q   <= set_d;
         fo_q    <= fo_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         rdy_q   <= 1'b1;
      end
   end

   assign select       = sel_q;
   assign req.req_ready = ready_w;
   assign req.busy     = busy_w;
   assign req.done     = done_q;
   assign req.err      = err_q;
   assign req.err_code = code_q;
endmodule
